// File: rtl/vram_port_responder_if.sv
// vram_port_responder_if: VDP request bus and VRAM port signals between arbiter/memory and the responder
interface vram_port_responder_if;
   logic [1:0]  DOTSTATE;
   logic [16:0] IRAMADR;
   logic [7:0]  PRAMDBO;
   logic [31:0] PRAMDBO_32;
   logic        PRAMWE_N;
   logic [1:0]  PRAM_SIZE;
   logic [7:0]  PRAMDAT;
   logic [31:0] PRAMDAT_32;
   logic        VDP_RD_VALID;
   logic        DROP_STICKY;
   logic [7:0]  DROP_COUNT;
   logic [15:0] MEM_ADDR;
   logic [15:0] MEM_DQ_OUT;
   logic        MEM_DQ_OE;
   logic        MEM_WE_N;
   logic [1:0]  MEM_BE_N;
   logic [15:0] MEM_DIN;
   modport master (
      output DOTSTATE, IRAMADR, PRAMDBO, PRAMDBO_32, PRAMWE_N, PRAM_SIZE, MEM_DIN,
      input  PRAMDAT, PRAMDAT_32, VDP_RD_VALID, DROP_STICKY, DROP_COUNT,
             MEM_ADDR, MEM_DQ_OUT, MEM_DQ_OE, MEM_WE_N, MEM_BE_N
   );
   modport slave (
      input  DOTSTATE, IRAMADR, PRAMDBO, PRAMDBO_32, PRAMWE_N, PRAM_SIZE, MEM_DIN,
      output PRAMDAT, PRAMDAT_32, VDP_RD_VALID, DROP_STICKY, DROP_COUNT,
             MEM_ADDR, MEM_DQ_OUT, MEM_DQ_OE, MEM_WE_N, MEM_BE_N
   );
endinterface

// File: rtl/vram_port_responder.sv
// vram_port_responder: executes sampled VDP requests on a 16-bit synchronous VRAM port; VRAM_RESP_DROP_COUNT_EN builds DROP_COUNT
module vram_port_responder (
   input logic                  CLK21M,
   input logic                  RESET,
   vram_port_responder_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2, CAPT = 2'd3;
   logic [1:0]  state_q, state_d, sz_q, sz_d, csz_q, csz_d, be_n_q, be_n_d, req_sz;
   logic        we_q, we_d, a0_q, a0_d, ca0_q, ca0_d, cap_q, cap_d;
   logic        oe_q, oe_d, we_n_q, we_n_d, valid_q, valid_d, sticky_q, sticky_d;
   logic [14:0] wa_q, wa_d;
   logic [15:0] hi_q, hi_d, lo_q, lo_d, addr_q, addr_d, dq_q, dq_d, src;
   logic [7:0]  byte_q, byte_d;
   logic [31:0] word_q, word_d;
   logic        sample, busy, take, drop, rd_last, nxt1;
   // request acceptance, beat sequencing and read capture
   always_comb begin
      sample   = bus.DOTSTATE[1] == bus.DOTSTATE[0];
      nxt1     = state_q == BEAT0 && sz_q == 2'd2;
      busy     = nxt1 || state_q == BEAT1;
      take     = sample && !busy;
      drop     = sample && busy;
      rd_last  = !we_q && (state_q == BEAT1 || (state_q == BEAT0 && sz_q != 2'd2));
      req_sz   = bus.PRAM_SIZE == 2'd3 ? 2'd0 : bus.PRAM_SIZE;
      state_d  = take ? BEAT0 : nxt1 ? BEAT1 : rd_last ? CAPT : IDLE;
      sz_d     = take ? req_sz : sz_q;
      we_d     = take ? !bus.PRAMWE_N : we_q;
      a0_d     = take ? bus.IRAMADR[0] : a0_q;
      wa_d     = take ? bus.IRAMADR[16:2] : wa_q;
      hi_d     = take ? bus.PRAMDBO_32[31:16] : hi_q;
      addr_d   = take ? (req_sz == 2'd2 ? {bus.IRAMADR[16:2], 1'b0} : bus.IRAMADR[16:1])
                      : nxt1 ? {wa_q, 1'b1} : addr_q;
      dq_d     = take ? (req_sz == 2'd0 ? {bus.PRAMDBO, bus.PRAMDBO} : bus.PRAMDBO_32[15:0])
                      : nxt1 ? hi_q : dq_q;
      be_n_d   = take ? (req_sz == 2'd0 ? (bus.IRAMADR[0] ? 2'b01 : 2'b10) : 2'b00) : be_n_q;
      we_n_d   = take ? bus.PRAMWE_N : nxt1 ? !we_q : 1'b1;
      oe_d     = !we_n_d;
      lo_d     = state_q == BEAT1 && !we_q ? bus.MEM_DIN : lo_q;
      cap_d    = rd_last;
      csz_d    = rd_last ? sz_q : csz_q;
      ca0_d    = rd_last ? a0_q : ca0_q;
      src      = csz_q == 2'd2 ? lo_q : bus.MEM_DIN;
      byte_d   = cap_q ? (ca0_q ? src[15:8] : src[7:0]) : byte_q;
      word_d   = !cap_q ? word_q : csz_q == 2'd2 ? {bus.MEM_DIN, lo_q}
               : csz_q == 2'd1 ? {16'h0, bus.MEM_DIN} : {24'h0, byte_d};
      valid_d  = cap_q;
      sticky_d = sticky_q | drop;
   end
   // state, latched request and port/result registers
   always_ff @(posedge CLK21M or posedge RESET) begin
      if (RESET) begin
         state_q  <= IDLE;
         sz_q     <= 2'd0;
         csz_q    <= 2'd0;
         we_q     <= 1'b0;
         a0_q     <= 1'b0;
         ca0_q    <= 1'b0;
         cap_q    <= 1'b0;
         wa_q     <= 15'd0;
         hi_q     <= 16'd0;
         lo_q     <= 16'd0;
         addr_q   <= 16'd0;
         dq_q     <= 16'd0;
         be_n_q   <= 2'b11;
         we_n_q   <= 1'b1;
         oe_q     <= 1'b0;
         byte_q   <= 8'd0;
         word_q   <= 32'd0;
         valid_q  <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sz_q     <= sz_d;
         csz_q    <= csz_d;
         we_q     <= we_d;
         a0_q     <= a0_d;
         ca0_q    <= ca0_d;
         cap_q    <= cap_d;
         wa_q     <= wa_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         addr_q   <= addr_d;
         dq_q     <= dq_d;
         be_n_q   <= be_n_d;
         we_n_q   <= we_n_d;
         oe_q     <= oe_d;
         byte_q   <= byte_d;
         word_q   <= word_d;
         valid_q  <= valid_d;
         sticky_q <= sticky_d;
      end
   end
`ifdef VRAM_RESP_DROP_COUNT_EN
   logic [7:0] cnt_q, cnt_d;
   // saturating count of rejected sample points
   always_comb cnt_d = drop && cnt_q != 8'hFF ? cnt_q + 8'd1 : cnt_q;
   // counter register, cleared only by reset
   always_ff @(posedge CLK21M or posedge RESET) cnt_q <= RESET ? 8'd0 : cnt_d;
   assign bus.DROP_COUNT = cnt_q;
`else
   assign bus.DROP_COUNT = 8'd0;
`endif
   assign bus.MEM_ADDR     = addr_q;
   assign bus.MEM_DQ_OUT   = dq_q;
   assign bus.MEM_DQ_OE    = oe_q;
   assign bus.MEM_WE_N     = we_n_q;
   assign bus.MEM_BE_N     = be_n_q;
   assign bus.PRAMDAT      = byte_q;
   assign bus.PRAMDAT_32   = word_q;
   assign bus.VDP_RD_VALID = valid_q;
   assign bus.DROP_STICKY  = sticky_q;
endmodule
